// File: rtl/sram_rw_arb.sv
// sram_rw_arb: shares the RW0 port of one single-port cache SRAM macro between
// a read-only core path (A) and a read/write refill/writeback path (B).
// Grants are combinational and read data returns one cycle after grant.
// B wins contention unless A has already lost STARVE_MAX times in a row.
// Optional feature: define SRAM_ARB_INIT_SWEEP_EN to zero-fill the whole array
// after every reset before any request is granted.
module sram_rw_arb #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned MASK_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_req_addr,
  output logic              a_resp_valid,
  output logic [DATA_W-1:0] a_resp_data,

  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [MASK_W-1:0] b_req_mask,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] b_resp_data,

  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata,

  output logic              init_done
);

  // A zero-width counter is not legal, so strict-priority mode keeps one bit.
  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic              in_init;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef SRAM_ARB_INIT_SWEEP_EN
  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  // Sweep state and address register; reset always restarts the sweep at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Walk every address once, then hand the port to the requesters for good.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {ADDR_W{1'b1}}) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign in_init    = (state_q == StInit);
  assign sweep_addr = sweep_q;
  assign init_done  = (state_q == StRun);
`else
  assign in_init    = 1'b0;
  assign sweep_addr = '0;
  assign init_done  = 1'b1;
`endif

  logic            a_grant, b_grant;
  logic [CntW-1:0] starve_q, starve_d;
  logic            a_resp_valid_q, b_resp_valid_q;

  // Same-cycle arbitration; nothing is granted while in reset or sweeping.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (reset_n && !in_init) begin
      if (a_req_valid && b_req_valid) begin
        if (starve_q == StarveMax) begin
          a_grant = 1'b1;
        end else begin
          b_grant = 1'b1;
        end
      end else begin
        a_grant = a_req_valid;
        b_grant = b_req_valid;
      end
    end
  end

  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;

  // Steer the macro port from the sweep, the winner, or idle it.
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (in_init) begin
      if (reset_n) begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = sweep_addr;
        RW0_wmask = '1;
      end
    end else if (a_grant) begin
      RW0_en   = 1'b1;
      RW0_addr = a_req_addr;
    end else if (b_grant) begin
      RW0_en    = 1'b1;
      RW0_wmode = b_req_write;
      RW0_addr  = b_req_addr;
      RW0_wmask = b_req_mask;
      RW0_wdata = b_req_wdata;
    end
  end

  // Count consecutive B wins against a waiting A, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!a_req_valid || a_grant) begin
      starve_d = '0;
    end else if (b_grant && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Response valids trail a read grant by one cycle; writes never respond.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_resp_valid_q <= 1'b0;
      b_resp_valid_q <= 1'b0;
    end else begin
      a_resp_valid_q <= a_grant;
      b_resp_valid_q <= b_grant && !b_req_write;
    end
  end

  assign a_resp_valid = a_resp_valid_q;
  assign b_resp_valid = b_resp_valid_q;
  // The macro holds its read data, so both ports simply observe it.
  assign a_resp_data  = RW0_rdata;
  assign b_resp_data  = RW0_rdata;

endmodule

// File: doc/sram_rw_arb.md
# sram_rw_arb

Arbiter and sequencer for one single-port read/write cache SRAM macro: a 10-bit address, 128-bit data, 16-lane byte mask, with a synchronous read and data one cycle later. It shares the macro's RW0 port between two requesters:
- port A, the core read path, read only;
- port B, the refill/writeback path, read or write.

It returns read data one cycle after grant. With the init feature compiled in, it zero-fills the whole array after reset before accepting traffic. It sits between the cache control logic and the `*_ext` SRAM instance.

## Interface
Parameters:
- ADDR_W, 10, SRAM address width (depth 2^ADDR_W).
- DATA_W, 128, SRAM data width.
- MASK_W, 16, write-mask lanes; DATA_W must be a multiple of MASK_W.
- STARVE_MAX, 4, number of consecutive B wins tolerated while A waits; 0 means A has strict priority.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req_valid  in  1  A read request.
- a_req_ready  out  1  A request granted this cycle.
- a_req_addr  in  ADDR_W  A read address.
- a_resp_valid  out  1  A read data valid.
- a_resp_data  out  DATA_W  A read data.
- b_req_valid  in  1  B request.
- b_req_ready  out  1  B request granted this cycle.
- b_req_write  in  1  1 = write, 0 = read.
- b_req_addr  in  ADDR_W  B address.
- b_req_mask  in  MASK_W  B write lane mask.
- b_req_wdata  in  DATA_W  B write data.
- b_resp_valid  out  1  B read data valid (never set for writes).
- b_resp_data  out  DATA_W  B read data.
- RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata  out  ADDR_W/1/1/MASK_W/DATA_W  macro controls.
- RW0_rdata  in  DATA_W  macro read data.
- init_done  out  1  array is usable.

## Operation
- There are two states: INIT and RUN. Reset forces INIT with sweep counter 0 when the feature is compiled in, and RUN otherwise.
- **INIT:**
  - RW0_en=1, RW0_wmode=1, RW0_wmask all ones, RW0_wdata=0, RW0_addr=sweep counter.
  - The counter increments every cycle.
  - After writing address 2^ADDR_W-1 the FSM goes to RUN.
  - Both ready outputs are 0 throughout INIT.
- **RUN arbitration** (combinational, same cycle):
  - Only one requester valid: that requester wins.
  - Both valid: B wins unless starve_cnt==STARVE_MAX, in which case A wins.
  - Winner's ready=1, loser's ready=0.
  - RW0_* is driven from the winner. For A, RW0_wmode=0. For B, RW0_wmode=b_req_write.
  - With no winner, RW0_en=0.
- **starve_cnt** (width clog2(STARVE_MAX+1)):
  - Increments when a_req_valid=1 and B wins.
  - Clears when A wins or a_req_valid=0.
  - Saturates at STARVE_MAX.
- **Responses:**
  - a_resp_valid/b_resp_valid are registered: set to 1 in the cycle after that port's read grant, otherwise 0.
  - A B write never produces a response.
  - a_resp_data and b_resp_data both carry RW0_rdata combinationally. They are meaningful only while the corresponding valid is high.
- There is no response backpressure. Requesters must sink the response in the cycle it appears.
- Read-after-write ordering is the grant order. A read granted the cycle after a write to the same address returns the new data.

## Timing
- Grant: in the same cycle as valid; no added latency.
- Read latency: response one cycle after grant. Back-to-back reads are sustained at one per cycle, in any mix of A and B.
- Reset values:
  - a_req_ready=0, b_req_ready=0, a_resp_valid=0, b_resp_valid=0, RW0_en=0, starve_cnt=0.
  - init_done=0 with the feature compiled in, 1 without it.
- While reset_n=0: RW0_en=0 and both ready outputs are 0.
- Sweep: the first write occurs in the first clock after reset_n deassertion. init_done rises in the cycle after the final sweep write, i.e. 2^ADDR_W cycles after reset release.
- Reset asserted mid-sweep restarts the sweep at address 0. Reset with a response pending drops that response.
- A request held valid across INIT is granted in the first RUN cycle.

## Configuration
- SRAM_ARB_INIT_SWEEP_EN defined:
  - The INIT state and sweep counter are built.
  - The array is zeroed after every reset.
  - init_done follows the sweep as described under Timing.
- SRAM_ARB_INIT_SWEEP_EN undefined:
  - No sweep logic is built.
  - The FSM is permanently in RUN and init_done is tied to 1.
  - Requests are accepted in the first cycle after reset release; array contents are undefined until written.

## Test plan
1. Sweep (macro on, ADDR_W=10): release reset → 1024 consecutive writes to addresses 0..1023 with full mask and data 0. init_done=1 at cycle 1024. A read of address 0x3FF then returns 0.
2. Basic read: B writes 0xA5..A5 with full mask to 0x010; A reads 0x010 in the next cycle → a_resp_valid=1 one cycle later with data 0xA5..A5.
3. Masked write: B writes mask 0x0001 with data 0xFF..FF to 0x020 (previously zeroed); B then reads 0x020 → b_resp_data=0x...00FF.
4. Starvation (STARVE_MAX=4): A and B both valid continuously → B wins 4 cycles, A wins the 5th, and the pattern repeats.
5. Contention: simultaneous A and B reads with starve_cnt=0 → B granted; next cycle b_resp_valid=1 and a_resp_valid=0.
6. Reset at sweep address 500 → the sweep restarts at 0 and init_done stays 0 until 1024 cycles after the new release.
